// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   // ceil(w * log10(2)): digits needed so 2^w-1 never overflows.
   function automatic int unsigned digits_for_width(input int unsigned w);
      int unsigned d;
      d = (w * 30103 + 99999) / 100000;
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready bus between a binary producer and the BCD converter.
interface bin2bcd_seq_if #(
   parameter int unsigned W = 14,
   parameter int unsigned D = 4
);

   logic                                 in_valid;
   logic                                 in_ready;
   logic [W-1:0]                         bin;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [bcd_pkg::BCD_DIGIT_W*D-1:0]    bcd;
   logic                                 ovf;
   logic [D-1:0]                         blank;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, ovf, blank
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, ovf, blank
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit greater than 4.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit per clock, all digits corrected in parallel,
// with sticky overflow detection and a leading-zero blanking mask.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned W = 14,
   parameter int unsigned D = 4
) (
   input logic          clk,
   input logic          rst,
   bin2bcd_seq_if.slave bus
);

   localparam int unsigned AW = BCD_DIGIT_W * D;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   state_e          state_q, state_d;
   logic [W-1:0]    binreg_q, binreg_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [AW-1:0]   acc_adj, acc_shift;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sticky_q, sticky_d, sticky_next;
   logic [AW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic [D-1:0]    blank_q, blank_d, blank_calc;
   logic            out_valid_q, out_valid_d;
   logic            in_ready;
   logic            accept;

   for (genvar i = 0; i < D; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (acc_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .digit_o (acc_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

   // The MSB of the binary register enters the ones digit; binreg itself is never corrected.
   assign acc_shift   = {acc_adj[AW-2:0], binreg_q[W-1]};
   assign sticky_next = sticky_q | acc_adj[AW-1];

   for (genvar i = 0; i < D; i++) begin : g_blank
      if (i == 0) begin : g_ones
         assign blank_calc[i] = 1'b0;
      end else begin : g_upper
         assign blank_calc[i] = (acc_shift[AW-1:BCD_DIGIT_W*i] == '0);
      end
   end

   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = bus.out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = bus.in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      binreg_d    = binreg_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sticky_d    = sticky_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      blank_d     = blank_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: ;
         SHIFT: begin
            acc_d    = acc_shift;
            binreg_d = binreg_q << 1;
            sticky_d = sticky_next;
            if (cnt_q == '0) begin
               bcd_d       = acc_shift;
               ovf_d       = sticky_next;
               blank_d     = blank_calc;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A load in DONE retires the old result on the same edge.
      if (accept) begin
         binreg_d = bus.bin;
         acc_d    = '0;
         sticky_d = 1'b0;
         cnt_d    = CW'(W - 1);
         state_d  = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         binreg_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sticky_q    <= 1'b0;
         bcd_q       <= '0;
         ovf_q       <= 1'b0;
         blank_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         binreg_q    <= binreg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
         blank_q     <= blank_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd       = bcd_q;
   assign bus.ovf       = ovf_q;
   assign bus.blank     = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq at W=14/D=4, plus a W=1..20 width sweep.
module tb_bin2bcd_seq;

   localparam int unsigned TW = 14;
   localparam int unsigned TD = 4;

   typedef struct packed {
      logic [15:0] bcd;
      logic        ovf;
      logic [3:0]  blank;
   } exp_t;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   exp_t sb_q[$];

   bin2bcd_seq_if #(.W(TW), .D(TD)) mif ();

   bin2bcd_seq #(.W(TW), .D(TD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif.slave)
   );

   logic        sw_valid;
   logic [19:0] sw_bin;
   logic [31:0] sw_bcd [1:20];
   logic        sw_ov  [1:20];
   logic        sw_ovf [1:20];

   for (genvar g = 1; g <= 20; g++) begin : g_sweep
      localparam int unsigned SD = bcd_pkg::digits_for_width(g);
      bin2bcd_seq_if #(.W(g), .D(SD)) sif ();
      bin2bcd_seq #(.W(g), .D(SD)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (sif.slave)
      );
      assign sif.in_valid  = sw_valid;
      assign sif.bin       = sw_bin[g-1:0];
      assign sif.out_ready = 1'b1;
      assign sw_bcd[g]     = 32'(sif.bcd);
      assign sw_ov[g]      = sif.out_valid;
      assign sw_ovf[g]     = sif.ovf;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dec_bcd(input int unsigned v, input int unsigned d);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(d)) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
         end
      end
      return r;
   endfunction

   function automatic logic bad_digit(input logic [31:0] b);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic exp_t model(input int unsigned v);
      exp_t e;
      int unsigned m;
      m = v % 10000;
      e.bcd   = 16'(dec_bcd(m, 4));
      e.ovf   = (v >= 10000);
      e.blank = {(m < 1000), (m < 100), (m < 10), 1'b0};
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Drive at a negedge; the following posedge is the accept edge.
   task automatic start(input int unsigned v);
      check("in_ready_before_load", 32'(mif.in_ready), 32'd1);
      mif.bin      = 14'(v);
      mif.in_valid = 1'b1;
      sb_q.push_back(model(v));
   endtask

   task automatic finish_check();
      exp_t e;
      int   lat;
      @(negedge clk);
      mif.in_valid = 1'b0;
      check("in_ready_shift", 32'(mif.in_ready), 32'd0);
      check("out_valid_shift", 32'(mif.out_valid), 32'd0);
      lat = 0;
      while (mif.out_valid !== 1'b1 && lat < int'(TW) + 10) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(TW));
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("bcd", 32'(mif.bcd), 32'(e.bcd));
         check("ovf", 32'(mif.ovf), 32'(e.ovf));
         check("blank", 32'(mif.blank), 32'(e.blank));
         check("digit_range", 32'(bad_digit(32'(mif.bcd))), 32'd0);
      end
   endtask

   initial begin
      logic [19:0]  r;
      bit           seen [1:20];
      int           lat;
      int           nseen;
      int unsigned  v;
      n_assert     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      mif.in_valid = 1'b0;
      mif.bin      = '0;
      mif.out_ready = 1'b1;
      sw_valid     = 1'b0;
      sw_bin       = '0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(mif.out_valid), 32'd0);
      check("rst_bcd", 32'(mif.bcd), 32'd0);
      check("rst_ovf", 32'(mif.ovf), 32'd0);
      check("rst_blank", 32'(mif.blank), 32'd0);
      check("rst_in_ready", 32'(mif.in_ready), 32'd1);
      rst = 1'b0;

      @(negedge clk); start(9999);  finish_check();
      @(negedge clk); start(10000); finish_check();
      @(negedge clk); start(16383); finish_check();
      @(negedge clk); start(0);     finish_check();
      @(negedge clk); start(205);   finish_check();

      @(negedge clk);
      check("retired_out_valid", 32'(mif.out_valid), 32'd0);
      check("retired_bcd", 32'(mif.bcd), 32'h0205);
      check("retired_blank", 32'(mif.blank), 32'b1000);
      check("retired_in_ready", 32'(mif.in_ready), 32'd1);

      // Back-pressure: result must hold and new requests must be refused.
      mif.out_ready = 1'b0;
      start(777);
      finish_check();
      mif.bin      = 14'd99;
      mif.in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", 32'(mif.out_valid), 32'd1);
         check("bp_bcd", 32'(mif.bcd), 32'h0777);
         check("bp_in_ready", 32'(mif.in_ready), 32'd0);
      end
      mif.out_ready = 1'b1;
      #1;
      start(42);
      finish_check();

      // Reset lands on the 7th SHIFT edge.
      @(negedge clk);
      mif.bin      = 14'd555;
      mif.in_valid = 1'b1;
      @(negedge clk);
      mif.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", 32'(mif.out_valid), 32'd0);
      check("abort_bcd", 32'(mif.bcd), 32'd0);
      check("abort_in_ready", 32'(mif.in_ready), 32'd1);
      start(1234);
      finish_check();

      // Width sweep: all converters fed the same value masked to their width.
      for (int n = 0; n < 6; n++) begin
         r = (n == 0) ? 20'hFFFFF : (n == 1) ? 20'h0 : 20'($urandom);
         @(negedge clk);
         sw_bin   = r;
         sw_valid = 1'b1;
         @(negedge clk);
         sw_valid = 1'b0;
         for (int g = 1; g <= 20; g++) seen[g] = 1'b0;
         nseen = 0;
         lat   = 0;
         while (nseen < 20 && lat < 30) begin
            @(negedge clk);
            lat++;
            for (int g = 1; g <= 20; g++) begin
               if (sw_ov[g] === 1'b1 && !seen[g]) begin
                  seen[g] = 1'b1;
                  nseen++;
                  v = int'(r) & ((1 << g) - 1);
                  check($sformatf("sweep_w%0d_latency", g), 32'(lat), 32'(g));
                  check($sformatf("sweep_w%0d_bcd", g), sw_bcd[g],
                        dec_bcd(v, bcd_pkg::digits_for_width(g)));
                  check($sformatf("sweep_w%0d_ovf", g), 32'(sw_ovf[g]), 32'd0);
                  check($sformatf("sweep_w%0d_digit", g), 32'(bad_digit(sw_bcd[g])), 32'd0);
               end
            end
         end
         check("sweep_all_done", 32'(nseen), 32'd20);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
